inst_packet_queue: RTL

INST_PACKET_QUEUE -- requirements
Module: inst_packet_queue

---
 rtl/inst_packet_queue_pkg.sv | 27 ++
 rtl/inst_packet_queue_compactor.sv | 27 ++
 rtl/inst_packet_queue.sv | 115 +++++++++++
 3 files changed

// File: rtl/inst_packet_queue_pkg.sv
// Shared fetch-side definitions: field sizes, packet layout and queue defaults.
package inst_packet_queue_pkg;

  localparam int SIZE_INSTRUCTION = 32;
  localparam int SIZE_PC          = 32;
  localparam int SIZE_CTI_LOG     = 4;

  // Packet layout, MSB to LSB: {instruction, pc, targetAddr, ctiqTag, prediction}
  localparam int PKT_W = SIZE_INSTRUCTION + 2*SIZE_PC + SIZE_CTI_LOG + 1;

  localparam int PKT_PRED_LSB   = 0;
  localparam int PKT_TAG_LSB    = PKT_PRED_LSB + 1;
  localparam int PKT_TARGET_LSB = PKT_TAG_LSB + SIZE_CTI_LOG;
  localparam int PKT_PC_LSB     = PKT_TARGET_LSB + SIZE_PC;
  localparam int PKT_INST_LSB   = PKT_PC_LSB + SIZE_PC;

  localparam int IPQ_DEPTH        = 16;
  localparam int IPQ_FETCH_WIDTH  = 4;
  localparam int IPQ_DECODE_WIDTH = 4;
  localparam int IPQ_SLOTS        = 4;

  // Pull the pc field out of a packet.
  function automatic logic [SIZE_PC-1:0] pkt_pc(input logic [PKT_W-1:0] pkt);
    return pkt[PKT_PC_LSB +: SIZE_PC];
  endfunction

endpackage

// File: rtl/inst_packet_queue_compactor.sv
// Packs the valid slots of a fetch bundle to the front, preserving slot order.
module packet_compactor #(
  parameter int PKT_W = inst_packet_queue_pkg::PKT_W
) (
  input  logic [3:0]       valid,
  input  logic [PKT_W-1:0] pkt      [4],
  output logic [PKT_W-1:0] cpkt     [4],
  output logic [2:0]       push_n
);
  import inst_packet_queue_pkg::*;

  logic [2:0] n;

  // Walk slots oldest-first, dropping each valid packet into the next free position.
  always_comb begin
    n = '0;
    for (int i = 0; i < IPQ_SLOTS; i++) cpkt[i] = '0;
    for (int i = 0; i < IPQ_SLOTS; i++) begin
      if (valid[i]) begin
        cpkt[n[1:0]] = pkt[i];
        n = n + 3'd1;
      end
    end
    push_n = n;
  end

endmodule

// File: rtl/inst_packet_queue.sv
// Circular instruction-packet queue between FetchStage2 and decode.
module inst_packet_queue #(
  parameter int DEPTH        = inst_packet_queue_pkg::IPQ_DEPTH,
  parameter int FETCH_WIDTH  = inst_packet_queue_pkg::IPQ_FETCH_WIDTH,
  parameter int DECODE_WIDTH = inst_packet_queue_pkg::IPQ_DECODE_WIDTH,
  parameter int PKT_W        = inst_packet_queue_pkg::PKT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       recoverFlag_i,
  input  logic                       fs2Ready_i,
  input  logic                       inst0Valid_i,
  input  logic                       inst1Valid_i,
  input  logic                       inst2Valid_i,
  input  logic                       inst3Valid_i,
  input  logic [PKT_W-1:0]           inst0Packet_i,
  input  logic [PKT_W-1:0]           inst1Packet_i,
  input  logic [PKT_W-1:0]           inst2Packet_i,
  input  logic [PKT_W-1:0]           inst3Packet_i,
  input  logic                       decodeReady_i,
  output logic                       inst0Valid_o,
  output logic                       inst1Valid_o,
  output logic                       inst2Valid_o,
  output logic                       inst3Valid_o,
  output logic [PKT_W-1:0]           inst0Packet_o,
  output logic [PKT_W-1:0]           inst1Packet_o,
  output logic [PKT_W-1:0]           inst2Packet_o,
  output logic [PKT_W-1:0]           inst3Packet_o,
  output logic                       stall_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  import inst_packet_queue_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;

  logic [3:0]       in_vld;
  logic [PKT_W-1:0] in_pkt  [4];
  logic [PKT_W-1:0] cmp_pkt [4];
  logic [PKT_W-1:0] out_pkt [4];
  logic [2:0]       push_n;
  logic [CW-1:0]    free_slots, push_amt, pop_amt;
  logic             kill, push_en, pop_en;

  assign in_vld    = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};
  assign in_pkt[0] = inst0Packet_i;
  assign in_pkt[1] = inst1Packet_i;
  assign in_pkt[2] = inst2Packet_i;
  assign in_pkt[3] = inst3Packet_i;

  packet_compactor #(.PKT_W(PKT_W)) u_compactor (
    .valid  (in_vld),
    .pkt    (in_pkt),
    .cpkt   (cmp_pkt),
    .push_n (push_n)
  );

  // Stall looks only at the registered occupancy, so a same-cycle pop never relaxes it.
  assign free_slots = CW'(DEPTH) - count;
  assign stall_o    = free_slots < CW'(FETCH_WIDTH);

  assign kill     = flush_i | recoverFlag_i;
  assign push_en  = fs2Ready_i & ~stall_o & ~kill;
  assign pop_en   = decodeReady_i & ~kill;
  assign push_amt = push_en ? CW'(push_n) : '0;
  assign pop_amt  = !pop_en ? '0 :
                    (count < CW'(DECODE_WIDTH)) ? count : CW'(DECODE_WIDTH);

  // Pointer and occupancy update; reset beats flush/recover, which beat push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (kill) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_amt[PW-1:0];
      tail  <= tail + push_amt[PW-1:0];
      count <= count + push_amt - pop_amt;
    end
  end

  // Storage write of the compacted bundle at tail, tail+1, ...; array itself is never cleared.
  always_ff @(posedge clk) begin
    if (reset && push_en) begin
      for (int k = 0; k < IPQ_SLOTS; k++) begin
        if (3'(k) < push_n) mem[tail + PW'(k)] <= cmp_pkt[k];
      end
    end
  end

  // Present the oldest four entries starting at head.
  always_comb begin
    for (int k = 0; k < IPQ_SLOTS; k++) out_pkt[k] = mem[head + PW'(k)];
  end

  assign inst0Valid_o  = count > CW'(0);
  assign inst1Valid_o  = count > CW'(1);
  assign inst2Valid_o  = count > CW'(2);
  assign inst3Valid_o  = count > CW'(3);
  assign inst0Packet_o = out_pkt[0];
  assign inst1Packet_o = out_pkt[1];
  assign inst2Packet_o = out_pkt[2];
  assign inst3Packet_o = out_pkt[3];
  assign count_o       = count;

endmodule
